// File: rtl/cam_capture_pack.sv
// Camera capture packer: samples a vsync_n/href/pixel stream and packs pixel pairs into
// SOF/EOF-tagged words for the frame-buffer write FIFO, holding one word back so EOF can be marked.
module cam_capture_pack #(
    parameter int DSIZE = 36,
    parameter int PIX_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_en,
    input  logic             vsync_n,
    input  logic             href,
    input  logic [PIX_W-1:0] pix_data,
    output logic             wr_vld,
    input  logic             wr_rdy,
    output logic [DSIZE-1:0] wr_data,
    output logic             cap_active,
    output logic             cap_overrun,
    output logic             line_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int SOF_B = 2 * PIX_W;
    localparam int EOF_B = 2 * PIX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACTIVE, S_DROP} state_t;

    state_t             state_q, state_d;
    logic               vsync_n_d1_q;
    logic               phase_q;
    logic [PIX_W-1:0]   lo_q;
    logic               sof_pend_q;
    logic [SOF_B:0]     hold_q;
    logic               hold_vld_q;
    logic               wr_vld_q;
    logic [DSIZE-1:0]   wr_data_q;
    logic [CNT_W-1:0]   run_cnt_q;
    logic [CNT_W-1:0]   frame_cnt_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic               overrun_q;
    logic               line_err_q;

    logic               vs_fe, in_act, form, flush, need_move, can_move, move, ovr, new_frame;
    logic [DSIZE-1:0]   out_word;

    assign vs_fe     = !vsync_n && vsync_n_d1_q;
    assign in_act    = (state_q == S_ACTIVE);
    assign form      = in_act && !vs_fe && href && phase_q;
    assign flush     = in_act && vs_fe && hold_vld_q;
    assign need_move = flush || (form && hold_vld_q);
    assign can_move  = !wr_vld_q || wr_rdy;
    assign move      = need_move && can_move;
    assign ovr       = need_move && !can_move;
    assign new_frame = vs_fe && (state_d == S_ACTIVE);

    // The held word leaves with EOF only when it is flushed by the frame boundary.
    always_comb begin
        out_word             = '0;
        out_word[SOF_B:0]    = hold_q;
        out_word[EOF_B]      = flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cap_en) state_d = S_ARM;
            S_ARM:    if (!cap_en) state_d = S_IDLE;
                      else if (vs_fe) state_d = S_ACTIVE;
            S_ACTIVE: if (ovr) state_d = S_DROP;
                      else if (vs_fe) state_d = cap_en ? S_ACTIVE : S_IDLE;
            S_DROP:   if (vs_fe) state_d = cap_en ? S_ACTIVE : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cap_active = (state_q == S_ACTIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_n_d1_q <= 1'b1;
            phase_q      <= 1'b0;
            lo_q         <= '0;
            sof_pend_q   <= 1'b1;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            wr_vld_q     <= 1'b0;
            wr_data_q    <= '0;
            run_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            word_cnt_q   <= '0;
            overrun_q    <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            vsync_n_d1_q <= vsync_n;

            if (move) begin
                wr_vld_q  <= 1'b1;
                wr_data_q <= out_word;
            end else if (wr_rdy) begin
                wr_vld_q  <= 1'b0;
            end

            if (ovr) overrun_q <= 1'b1;

            if (flush && can_move) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
                word_cnt_q  <= (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1;
            end

            if (new_frame) begin
                run_cnt_q <= '0;
            end else if (move && !flush && run_cnt_q != '1) begin
                run_cnt_q <= run_cnt_q + 1'b1;
            end

            // A pixel coincident with the boundary starts the next frame, if there is one.
            if (new_frame) begin
                sof_pend_q <= 1'b1;
                hold_vld_q <= 1'b0;
                phase_q    <= href;
                if (href) lo_q <= pix_data;
            end else if (vs_fe) begin
                hold_vld_q <= 1'b0;
                phase_q    <= 1'b0;
            end else if (in_act) begin
                if (ovr) begin
                    hold_vld_q <= 1'b0;
                    phase_q    <= 1'b0;
                end else if (href && !phase_q) begin
                    lo_q    <= pix_data;
                    phase_q <= 1'b1;
                end else if (href) begin
                    hold_q     <= {sof_pend_q, pix_data, lo_q};
                    hold_vld_q <= 1'b1;
                    sof_pend_q <= 1'b0;
                    phase_q    <= 1'b0;
                end else if (phase_q) begin
                    line_err_q <= 1'b1;
                    phase_q    <= 1'b0;
                end
            end
        end
    end

    assign wr_vld      = wr_vld_q;
    assign wr_data     = wr_data_q;
    assign cap_overrun = overrun_q;
    assign line_err    = line_err_q;
    assign frame_cnt   = frame_cnt_q;
    assign word_cnt    = word_cnt_q;

endmodule
